// File: rtl/axi_stream_pkt_arb.sv
// rtl/axi_stream_pkt_arb.sv - packet-level round-robin stream arbiter with a registered output slot
// A grant is held from sop through eop so packets from different sources never interleave.
module axi_stream_pkt_arb #(
   parameter int NUM_IN   = 4,
   parameter int DAT_BYTS = 64,
   parameter int DAT_BITS = DAT_BYTS*8,
   parameter int CTL_BITS = 8,
   parameter int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1,
   parameter int SEL_BITS = $clog2(NUM_IN)
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NUM_IN-1:0]            i_val,
   input  logic [NUM_IN-1:0]            i_sop,
   input  logic [NUM_IN-1:0]            i_eop,
   input  logic [NUM_IN-1:0]            i_err,
   input  logic [NUM_IN*MOD_BITS-1:0]   i_mod,
   input  logic [NUM_IN*CTL_BITS-1:0]   i_ctl,
   input  logic [NUM_IN*DAT_BITS-1:0]   i_dat,
   output logic [NUM_IN-1:0]            o_rdy,
   output logic                         o_val,
   output logic                         o_sop,
   output logic                         o_eop,
   output logic                         o_err,
   output logic [MOD_BITS-1:0]          o_mod,
   output logic [CTL_BITS-1:0]          o_ctl,
   output logic [DAT_BITS-1:0]          o_dat,
   output logic [SEL_BITS-1:0]          o_sel,
   input  logic                         i_rdy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_LOCK = 1'b1;

   logic [0:0]          state;
   logic [SEL_BITS-1:0] rr_ptr;
   logic [SEL_BITS-1:0] lock_idx;
   logic [SEL_BITS-1:0] grant_idx;
   logic [SEL_BITS-1:0] cur_idx;
   logic                grant_found;
   logic                slot_free;
   logic                accept;
   logic                frame_err;
   logic                sel_sop;
   logic                sel_eop;
   logic                sel_err;
   logic [MOD_BITS-1:0] sel_mod;
   logic [CTL_BITS-1:0] sel_ctl;
   logic [DAT_BITS-1:0] sel_dat;

   function automatic logic [SEL_BITS-1:0] next_idx(input logic [SEL_BITS-1:0] idx);
      if (idx == SEL_BITS'(NUM_IN-1)) return '0;
      return idx + SEL_BITS'(1);
   endfunction

   // Output slot can take a beat when empty or being drained this cycle.
   assign slot_free = ~o_val | i_rdy;

   always_comb begin
      logic [SEL_BITS:0] k;
      k           = '0;
      grant_found = 1'b0;
      grant_idx   = rr_ptr;
      for (int i = 0; i < NUM_IN; i++) begin
         k = {1'b0, rr_ptr} + (SEL_BITS+1)'(i);
         if (k >= (SEL_BITS+1)'(NUM_IN)) k = k - (SEL_BITS+1)'(NUM_IN);
         if (!grant_found && i_val[k[SEL_BITS-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = k[SEL_BITS-1:0];
         end
      end
   end

   assign cur_idx = (state == ST_LOCK) ? lock_idx : grant_idx;

   // While locked the owner keeps its ready even through bubbles; everyone else waits.
   always_comb begin
      o_rdy = '0;
      if (!i_rst && slot_free && (state == ST_LOCK || grant_found)) o_rdy[cur_idx] = 1'b1;
   end

   assign accept  = |(o_rdy & i_val);
   assign sel_sop = i_sop[cur_idx];
   assign sel_eop = i_eop[cur_idx];
   assign sel_err = i_err[cur_idx];
   assign sel_mod = i_mod[int'(cur_idx)*MOD_BITS +: MOD_BITS];
   assign sel_ctl = i_ctl[int'(cur_idx)*CTL_BITS +: CTL_BITS];
   assign sel_dat = i_dat[int'(cur_idx)*DAT_BITS +: DAT_BITS];

   // A packet must open with sop in IDLE and must not restart with sop while locked.
   assign frame_err = (state == ST_IDLE) ? ~sel_sop : sel_sop;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_val <= 1'b0;
         o_sop <= 1'b0;
         o_eop <= 1'b0;
         o_err <= 1'b0;
         o_mod <= '0;
         o_ctl <= '0;
         o_dat <= '0;
         o_sel <= '0;
      end else if (accept) begin
         o_val <= 1'b1;
         o_sop <= sel_sop;
         o_eop <= sel_eop;
         o_err <= sel_err | frame_err;
         o_mod <= sel_mod;
         o_ctl <= sel_ctl;
         o_dat <= sel_dat;
         o_sel <= cur_idx;
      end else if (i_rdy) begin
         o_val <= 1'b0;
      end
   end

   // The pointer moves only at packet end, so fairness is per packet rather than per beat.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         lock_idx <= '0;
      end else if (accept) begin
         if (sel_eop) begin
            state  <= ST_IDLE;
            rr_ptr <= next_idx(cur_idx);
         end else begin
            state    <= ST_LOCK;
            lock_idx <= cur_idx;
         end
      end
   end

endmodule

// File: tb/tb_axi_stream_pkt_arb.sv
// tb/tb_axi_stream_pkt_arb.sv - directed and randomized bench for axi_stream_pkt_arb
module tb_axi_stream_pkt_arb;

   localparam int NUM_IN   = 4;
   localparam int DAT_BYTS = 8;
   localparam int DAT_BITS = 64;
   localparam int CTL_BITS = 8;
   localparam int MOD_BITS = 3;
   localparam int SEL_BITS = 2;

   typedef struct packed {
      logic                sop;
      logic                eop;
      logic                err;
      logic [MOD_BITS-1:0] mod;
      logic [CTL_BITS-1:0] ctl;
      logic [DAT_BITS-1:0] dat;
   } beat_t;

   logic                       i_clk;
   logic                       i_rst;
   logic [NUM_IN-1:0]          i_val;
   logic [NUM_IN-1:0]          i_sop;
   logic [NUM_IN-1:0]          i_eop;
   logic [NUM_IN-1:0]          i_err;
   logic [NUM_IN*MOD_BITS-1:0] i_mod;
   logic [NUM_IN*CTL_BITS-1:0] i_ctl;
   logic [NUM_IN*DAT_BITS-1:0] i_dat;
   logic [NUM_IN-1:0]          o_rdy;
   logic                       o_val;
   logic                       o_sop;
   logic                       o_eop;
   logic                       o_err;
   logic [MOD_BITS-1:0]        o_mod;
   logic [CTL_BITS-1:0]        o_ctl;
   logic [DAT_BITS-1:0]        o_dat;
   logic [SEL_BITS-1:0]        o_sel;
   logic                       i_rdy;

   axi_stream_pkt_arb #(
      .NUM_IN(NUM_IN), .DAT_BYTS(DAT_BYTS), .DAT_BITS(DAT_BITS),
      .CTL_BITS(CTL_BITS), .MOD_BITS(MOD_BITS), .SEL_BITS(SEL_BITS)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_val(i_val), .i_sop(i_sop), .i_eop(i_eop),
      .i_err(i_err), .i_mod(i_mod), .i_ctl(i_ctl), .i_dat(i_dat), .o_rdy(o_rdy),
      .o_val(o_val), .o_sop(o_sop), .o_eop(o_eop), .o_err(o_err), .o_mod(o_mod),
      .o_ctl(o_ctl), .o_dat(o_dat), .o_sel(o_sel), .i_rdy(i_rdy)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   beat_t             srcq [NUM_IN][$];
   int                mute [NUM_IN];
   bit                rand_val;
   bit                rand_rdy;
   bit                err_en;
   bit                rdy_pat [$];
   int                m_owner;
   int                m_ptr;
   bit                m_oval;
   beat_t             m_out;
   int                m_osel;
   int                tests;
   int                fails;
   int                cyc;
   int                log_sel [$];
   int                log_cyc [$];
   int                log_mod [$];
   bit                log_sop [$];
   bit                log_eop [$];
   bit                log_err [$];
   logic [DAT_BITS-1:0] log_dat [$];
   logic [NUM_IN-1:0] obs_rdy;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit busy();
      for (int k = 0; k < NUM_IN; k++) if (srcq[k].size() > 0) return 1'b1;
      return m_oval;
   endfunction

   task automatic clear_log();
      log_sel.delete(); log_cyc.delete(); log_mod.delete();
      log_sop.delete(); log_eop.delete(); log_err.delete(); log_dat.delete();
   endtask

   task automatic add_pkt(input int src, input int n, input int bad);
      for (int i = 0; i < n; i++) begin
         beat_t b;
         b.sop = (i == 0);
         b.eop = (i == n-1);
         b.err = err_en && ($urandom_range(9) == 0);
         b.mod = b.eop ? MOD_BITS'($urandom) : '0;
         b.ctl = CTL_BITS'($urandom);
         b.dat = {$urandom, $urandom};
         if (bad == 1 && i == 0) b.sop = 1'b0;
         if (bad == 2 && i == n-1 && n > 1) b.sop = 1'b1;
         srcq[src].push_back(b);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_oval  = 1'b0;
      m_out   = '0;
      m_osel  = 0;
      for (int k = 0; k < NUM_IN; k++) begin
         srcq[k].delete();
         mute[k] = 0;
      end
      rdy_pat.delete();
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < NUM_IN; k++) begin
         beat_t b;
         bit    on;
         on = (srcq[k].size() > 0) && (mute[k] == 0) && (!rand_val || $urandom_range(3) != 0);
         if (mute[k] > 0) mute[k]--;
         if (srcq[k].size() > 0) b = srcq[k][0];
         else begin
            b     = '0;
            b.ctl = CTL_BITS'($urandom);
            b.dat = {$urandom, $urandom};
         end
         i_val[k] = on;
         i_sop[k] = b.sop;
         i_eop[k] = b.eop;
         i_err[k] = b.err;
         i_mod[k*MOD_BITS +: MOD_BITS] = b.mod;
         i_ctl[k*CTL_BITS +: CTL_BITS] = b.ctl;
         i_dat[k*DAT_BITS +: DAT_BITS] = b.dat;
      end
      if (rdy_pat.size() > 0) i_rdy = rdy_pat.pop_front();
      else if (rand_rdy)      i_rdy = ($urandom_range(2) != 0);
      else                    i_rdy = 1'b1;
   endtask

   // One clock: drive at negedge, check ready, advance the packet-level model at posedge.
   task automatic step();
      logic [NUM_IN-1:0] exp_rdy;
      int    cand;
      bit    slot;
      bit    acc;
      beat_t b;
      drive_inputs();
      #1;
      slot    = !m_oval || i_rdy;
      exp_rdy = '0;
      cand    = -1;
      if (m_owner >= 0) cand = m_owner;
      else
         for (int i = 0; i < NUM_IN; i++)
            if (cand < 0 && i_val[(m_ptr+i) % NUM_IN]) cand = (m_ptr+i) % NUM_IN;
      if (cand >= 0 && slot) exp_rdy[cand] = 1'b1;
      acc     = (cand >= 0) && slot && i_val[cand];
      obs_rdy = o_rdy;
      chk("o_rdy", 128'(o_rdy), 128'(exp_rdy));
      @(posedge i_clk);
      if (acc) begin
         b       = srcq[cand].pop_front();
         b.err   = b.err | ((m_owner < 0) ? !b.sop : b.sop);
         m_out   = b;
         m_osel  = cand;
         m_oval  = 1'b1;
         if (b.eop) begin
            m_owner = -1;
            m_ptr   = (cand + 1) % NUM_IN;
         end else begin
            m_owner = cand;
         end
      end else if (i_rdy) begin
         m_oval = 1'b0;
      end
      #1;
      cyc++;
      chk("o_val", 128'(o_val), 128'(m_oval));
      if (m_oval)
         chk("beat", 128'({o_sop, o_eop, o_err, o_mod, o_ctl, o_dat, o_sel}),
             128'({m_out, SEL_BITS'(m_osel)}));
      if (acc) begin
         log_sel.push_back(int'(o_sel));
         log_cyc.push_back(cyc);
         log_mod.push_back(int'(o_mod));
         log_sop.push_back(o_sop);
         log_eop.push_back(o_eop);
         log_err.push_back(o_err);
         log_dat.push_back(o_dat);
      end
      @(negedge i_clk);
   endtask

   task automatic drain(input int max);
      int n;
      n = 0;
      while (busy() && n < max) begin
         step();
         n++;
      end
      chk("drain_done", 128'(busy()), 128'(0));
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      i_val = '0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [DAT_BITS-1:0] sent [$];
      beat_t               b;
      int                  n;
      int                  total;
      tests = 0; fails = 0; cyc = 0;
      rand_val = 1'b0; rand_rdy = 1'b0; err_en = 1'b0;
      i_rst = 1'b1; i_val = '1; i_sop = '0; i_eop = '0; i_err = '0;
      i_mod = '0; i_ctl = '0; i_dat = '0; i_rdy = 1'b1;
      model_reset();
      repeat (2) @(negedge i_clk);
      #1;
      chk("reset_outs", 128'({o_val, o_sop, o_eop, o_err, o_mod, o_ctl, o_dat, o_sel, o_rdy}), 128'(0));
      @(negedge i_clk);
      i_val = '0;
      i_rst = 1'b0;

      // 1: lone three-beat packet from src0
      clear_log();
      add_pkt(0, 3, 0);
      drain(20);
      chk("t1_cnt", 128'(log_sel.size()), 128'(3));
      for (int i = 0; i < 3 && i < log_sel.size(); i++) begin
         chk("t1_sel", 128'(log_sel[i]), 128'(0));
         chk("t1_sop_eop", 128'({log_sop[i], log_eop[i]}), 128'({i == 0, i == 2}));
      end
      if (log_cyc.size() == 3) chk("t1_b2b", 128'(log_cyc[2] - log_cyc[0]), 128'(2));

      // 2: four sources with two-beat packets, round-robin order
      do_reset();
      clear_log();
      for (int k = 0; k < NUM_IN; k++) add_pkt(k, 2, 0);
      drain(40);
      chk("t2_cnt", 128'(log_sel.size()), 128'(8));
      for (int i = 0; i < 8 && i < log_sel.size(); i++) chk("t2_order", 128'(log_sel[i]), 128'(i/2));
      if (log_cyc.size() == 8) chk("t2_b2b", 128'(log_cyc[7] - log_cyc[0]), 128'(7));
      clear_log();
      add_pkt(3, 1, 0);
      add_pkt(0, 1, 0);
      drain(20);
      if (log_sel.size() > 0) chk("t2_ptr0", 128'(log_sel[0]), 128'(0));
      else chk("t2_ptr0_cnt", 128'(log_sel.size()), 128'(2));

      // 3: src1 locked with a bubble while src2 waits
      clear_log();
      add_pkt(1, 3, 0);
      n = 0;
      while (srcq[1].size() > 2 && n < 10) begin step(); n++; end
      chk("t3_locked", 128'(srcq[1].size()), 128'(2));
      add_pkt(2, 1, 0);
      mute[1] = 5;
      repeat (5) begin
         step();
         chk("t3_rdy2", 128'(obs_rdy[2]), 128'(0));
      end
      drain(40);
      chk("t3_cnt", 128'(log_sel.size()), 128'(4));
      if (log_sel.size() == 4) begin
         chk("t3_src1_eop", 128'({log_sel[2], log_eop[2]}), 128'({32'd1, 1'b1}));
         chk("t3_src2_last", 128'(log_sel[3]), 128'(2));
      end

      // 4: downstream backpressure during a four-beat packet
      clear_log();
      repeat (3) begin
         rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
         rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
      end
      add_pkt(0, 4, 0);
      sent.delete();
      for (int i = 0; i < srcq[0].size(); i++) sent.push_back(srcq[0][i].dat);
      drain(40);
      chk("t4_cnt", 128'(log_dat.size()), 128'(4));
      for (int i = 0; i < 4 && i < log_dat.size(); i++) chk("t4_dat", 128'(log_dat[i]), 128'(sent[i]));
      rdy_pat.delete();

      // 5: framing error from src3, then alternating single-beat packets
      clear_log();
      b = '0; b.eop = 1'b1; b.mod = 3'd5; b.ctl = 8'h3c; b.dat = 64'h0123_4567_89ab_cdef;
      srcq[3].push_back(b);
      drain(20);
      chk("t5_cnt", 128'(log_sel.size()), 128'(1));
      if (log_sel.size() == 1)
         chk("t5_err_mod_sel", 128'({log_err[0], log_mod[0], log_sel[0]}), 128'({1'b1, 32'd5, 32'd3}));
      clear_log();
      for (int i = 0; i < 3; i++) begin add_pkt(0, 1, 0); add_pkt(1, 1, 0); end
      drain(30);
      chk("t5_alt_cnt", 128'(log_sel.size()), 128'(6));
      for (int i = 0; i < 6 && i < log_sel.size(); i++) chk("t5_alt", 128'(log_sel[i]), 128'(i % 2));
      if (log_cyc.size() == 6) chk("t5_b2b", 128'(log_cyc[5] - log_cyc[0]), 128'(5));

      // 6: asynchronous reset during beat 2 of a four-beat packet
      clear_log();
      add_pkt(0, 4, 0);
      n = 0;
      while (srcq[0].size() > 2 && n < 10) begin step(); n++; end
      chk("t6_mid", 128'({o_val, srcq[0].size()}), 128'({1'b1, 32'd2}));
      i_rst = 1'b1;
      #1;
      chk("t6_async_val", 128'(o_val), 128'(0));
      @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      model_reset();
      clear_log();
      add_pkt(2, 4, 0);
      drain(30);
      chk("t6_cnt", 128'(log_sel.size()), 128'(4));
      if (log_sel.size() > 0)
         chk("t6_first", 128'({log_sel[0], log_sop[0], log_err[0]}), 128'({32'd2, 1'b1, 1'b0}));

      // Randomized traffic, bubbles, backpressure and framing faults against the model
      for (int r = 0; r < 3; r++) begin
         do_reset();
         clear_log();
         rand_val = 1'b1; rand_rdy = 1'b1; err_en = 1'b1;
         total = 0;
         for (int k = 0; k < NUM_IN; k++)
            for (int p = 0; p < 4; p++) begin
               n = $urandom_range(1, 4);
               total += n;
               add_pkt(k, n, $urandom_range(0, 5));
            end
         drain(3000);
         chk("rand_cnt", 128'(log_sel.size()), 128'(total));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
